// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the platform interrupt controller: register word
// indices, ID width and the per-source gateway state encoding.
package irq_ctrl_pkg;

  localparam int ID_W = 5;

  localparam logic [5:0] IRQ_ENABLE    = 6'h00;
  localparam logic [5:0] IRQ_MODE      = 6'h01;
  localparam logic [5:0] IRQ_THRESH    = 6'h02;
  localparam logic [5:0] IRQ_CLAIM     = 6'h03;
  localparam logic [5:0] IRQ_PENDING   = 6'h04;
  localparam logic [5:0] IRQ_ACTIVE    = 6'h05;
  localparam logic [5:0] IRQ_PRIO_BASE = 6'h20;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_SERVICE = 2'd2
  } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: optional input synchroniser, edge detect and
// the IDLE/PEND/SERVICE handshake state. IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser.
module irq_gateway
  import irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic mode,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pend,
  output logic active
);

  logic      src_s;
  logic      src_prev;
  logic      rise;
  logic      req;
  logic      edge_seen_q, edge_seen_d;
  gw_state_e state_q, state_d;

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], src};
  end

  assign src_s = sync_q[1];
`else
  assign src_s = src;
`endif

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // combinational blocks use = and read their own intermediate results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev    <= 1'b0;
      state_q     <= GW_IDLE;
      edge_seen_q <= 1'b0;
    end else begin
      src_prev    <= src_s;
      state_q     <= state_d;
      edge_seen_q <= edge_seen_d;
    end
  end

  assign rise = src_s & ~src_prev;
  assign req  = mode ? rise : src_s;

  // NOTE: defaults first so no path leaves an output unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    edge_seen_d = edge_seen_q;
    case (state_q)
      GW_IDLE: if (req) state_d = GW_PEND;
      GW_PEND: begin
        if (claim_hit) begin
          state_d     = GW_SERVICE;
          edge_seen_d = mode & rise;
        end
      end
      GW_SERVICE: begin
        if (mode && rise) edge_seen_d = 1'b1;
        if (complete_hit) begin
          // A remembered edge re-pends at once; level sources re-sample from IDLE.
          state_d     = (mode && (edge_seen_q || rise)) ? GW_PEND : GW_IDLE;
          edge_seen_d = 1'b0;
        end
      end
      default: begin
        state_d     = GW_IDLE;
        edge_seen_d = 1'b0;
      end
    endcase
  end

  assign pend   = (state_q == GW_PEND);
  assign active = (state_q == GW_SERVICE);

endmodule

// File: rtl/irq_ctrl.sv
// Platform interrupt controller top: config registers, priority arbiter,
// claim/complete register port and the registered irq line. See IRQ_CTRL_SYNC_EN in irq_gateway.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC:1]   src,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [5:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               irq
);

  logic [NUM_SRC:1]  enable_q;
  logic [NUM_SRC:1]  mode_q;
  logic [PRIO_W-1:0] thresh_q;
  logic [PRIO_W-1:0] prio_q [1:NUM_SRC];
  logic [NUM_SRC:1]  pend;
  logic [NUM_SRC:1]  active;
  logic [NUM_SRC:1]  claim_hit;
  logic [NUM_SRC:1]  complete_hit;
  logic [ID_W-1:0]   winner;
  logic [PRIO_W-1:0] best_prio;
  logic              claim_rd;
  logic              complete_wr;

  assign claim_rd    = reg_re && (reg_addr == IRQ_CLAIM);
  assign complete_wr = reg_we && (reg_addr == IRQ_CLAIM);

  // NOTE: the priority array is a handful of flops, so it is reset like any
  // other register rather than treated as an unreset RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
    end else if (reg_we) begin
      case (reg_addr)
        IRQ_ENABLE: enable_q <= reg_wdata[NUM_SRC:1];
        IRQ_MODE:   mode_q   <= reg_wdata[NUM_SRC:1];
        IRQ_THRESH: thresh_q <= reg_wdata[PRIO_W-1:0];
        default: begin
          for (int i = 1; i <= NUM_SRC; i++)
            if (reg_addr == IRQ_PRIO_BASE + 6'(i)) prio_q[i] <= reg_wdata[PRIO_W-1:0];
        end
      endcase
    end
  end

  // Starting the running best at the threshold enforces prio > threshold;
  // strict > keeps the lowest ID on ties.
  always_comb begin
    winner    = '0;
    best_prio = thresh_q;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (pend[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        winner    = ID_W'(i);
      end
    end
  end

  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_src
    assign claim_hit[g]    = claim_rd && (winner == ID_W'(g));
    assign complete_hit[g] = complete_wr && (reg_wdata == 32'(g));

    irq_gateway u_gw (
      .clk          (clk),
      .rst          (rst),
      .src          (src[g]),
      .mode         (mode_q[g]),
      .claim_hit    (claim_hit[g]),
      .complete_hit (complete_hit[g]),
      .pend         (pend[g]),
      .active       (active[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= (winner != '0);
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      IRQ_ENABLE:  reg_rdata[NUM_SRC:1]  = enable_q;
      IRQ_MODE:    reg_rdata[NUM_SRC:1]  = mode_q;
      IRQ_THRESH:  reg_rdata[PRIO_W-1:0] = thresh_q;
      IRQ_CLAIM:   reg_rdata[ID_W-1:0]   = winner;
      IRQ_PENDING: reg_rdata[NUM_SRC:1]  = pend;
      IRQ_ACTIVE:  reg_rdata[NUM_SRC:1]  = active;
      default: begin
        for (int i = 1; i <= NUM_SRC; i++)
          if (reg_addr == IRQ_PRIO_BASE + 6'(i)) reg_rdata[PRIO_W-1:0] = prio_q[i];
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: expected values are queued when stimulus
// is driven and popped when the DUT output is sampled.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:1]  src = '0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [5:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        irq;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  irq_ctrl #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb.push_back('{tag: tag, exp: exp});
  endtask

  task automatic compare_front(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, act, e.exp);
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    reg_addr = a;
    reg_re   = 1'b1;
    expect_val(tag, exp);
    #1;
    compare_front(reg_rdata);
    @(posedge clk);
    #1;
    reg_re   = 1'b0;
    reg_addr = '0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(posedge clk);
    #1;
    reg_we    = 1'b0;
    reg_addr  = '0;
  endtask

  task automatic claim_complete(input logic [31:0] id, input logic [31:0] exp, input string tag);
    @(negedge clk);
    reg_re    = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = IRQ_CLAIM;
    reg_wdata = id;
    expect_val(tag, exp);
    #1;
    compare_front(reg_rdata);
    @(posedge clk);
    #1;
    reg_re = 1'b0;
    reg_we = 1'b0;
    reg_addr = '0;
  endtask

  task automatic chk_irq_now(input logic exp, input string tag);
    expect_val(tag, {31'b0, exp});
    compare_front({31'b0, irq});
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    @(negedge clk);
    chk_irq_now(exp, tag);
  endtask

  // mask uses register bit layout: bit i drives source i.
  task automatic pulse(input logic [8:0] mask);
    @(negedge clk);
    src = src | mask[8:1];
    @(negedge clk);
    src = src & ~mask[8:1];
  endtask

  task automatic settle();
    repeat (3 + SYNC_EXTRA) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    src = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset values, unmapped space and bit 0 of mask registers.
    rd(IRQ_ENABLE,  32'h0, "rst_enable");
    rd(IRQ_MODE,    32'h0, "rst_mode");
    rd(IRQ_THRESH,  32'h0, "rst_thresh");
    rd(IRQ_CLAIM,   32'h0, "rst_claim");
    rd(IRQ_PENDING, 32'h0, "rst_pending");
    rd(IRQ_ACTIVE,  32'h0, "rst_active");
    rd(6'h23,       32'h0, "rst_prio3");
    chk_irq(1'b0, "rst_irq");
    wr(6'h10, 32'hFFFF_FFFF);
    rd(6'h10, 32'h0, "unmapped_rd");
    wr(IRQ_ENABLE, 32'hFFFF_FFFF);
    rd(IRQ_ENABLE, 32'h0000_01FE, "enable_bit0");
    wr(IRQ_ENABLE, 32'h0);
    pulse(9'h008);
    settle();
    chk_irq_now(1'b0, "t1_disabled_irq");
    rd(IRQ_PENDING, 32'h08, "t1_pending_masked");

    // Edge latch and latency.
    do_reset();
    wr(IRQ_ENABLE, 32'h08);
    wr(IRQ_MODE, 32'h08);
    wr(6'h23, 32'd2);
    wr(IRQ_THRESH, 32'd0);
    pulse(9'h008);
    repeat (SYNC_EXTRA) @(negedge clk);
    chk_irq_now(1'b0, "t2_irq_early");
    chk_irq(1'b1, "t2_irq");
    rd(IRQ_PENDING, 32'h08, "t2_pending");
    rd(IRQ_CLAIM, 32'd3, "t2_claim");
    rd(IRQ_ACTIVE, 32'h08, "t2_active");
    chk_irq_now(1'b0, "t2_irq_after_claim");
    wr(IRQ_CLAIM, 32'd3);
    rd(IRQ_ACTIVE, 32'h0, "t2_active_done");

    // Priority and tie-break.
    do_reset();
    wr(IRQ_ENABLE, 32'h24);
    wr(IRQ_MODE, 32'h24);
    wr(6'h22, 32'd4);
    wr(6'h25, 32'd4);
    pulse(9'h024);
    settle();
    rd(IRQ_CLAIM, 32'd2, "t3_tie_first");
    rd(IRQ_CLAIM, 32'd5, "t3_tie_second");
    rd(IRQ_CLAIM, 32'd0, "t3_tie_none");
    wr(IRQ_CLAIM, 32'd2);
    wr(IRQ_CLAIM, 32'd5);
    wr(6'h25, 32'd6);
    pulse(9'h024);
    settle();
    rd(IRQ_CLAIM, 32'd5, "t3_prio_first");
    rd(IRQ_CLAIM, 32'd2, "t3_prio_second");
    wr(IRQ_CLAIM, 32'd5);
    wr(IRQ_CLAIM, 32'd2);
    rd(IRQ_ACTIVE, 32'h0, "t3_active_done");

    // Threshold.
    do_reset();
    wr(IRQ_ENABLE, 32'h02);
    wr(IRQ_MODE, 32'h02);
    wr(6'h21, 32'd3);
    wr(IRQ_THRESH, 32'd3);
    pulse(9'h002);
    settle();
    chk_irq_now(1'b0, "t4_irq_blocked");
    rd(IRQ_PENDING, 32'h02, "t4_pending");
    wr(IRQ_THRESH, 32'd2);
    chk_irq(1'b0, "t4_irq_same_cycle");
    chk_irq(1'b1, "t4_irq_next_cycle");
    rd(IRQ_CLAIM, 32'd1, "t4_claim");

    // Gateway blocking, edge mode.
    do_reset();
    wr(IRQ_ENABLE, 32'h08);
    wr(IRQ_MODE, 32'h08);
    wr(6'h23, 32'd2);
    pulse(9'h008);
    settle();
    rd(IRQ_CLAIM, 32'd3, "t5e_claim1");
    pulse(9'h008);
    pulse(9'h008);
    settle();
    rd(IRQ_PENDING, 32'h0, "t5e_no_repend");
    wr(IRQ_CLAIM, 32'd3);
    rd(IRQ_PENDING, 32'h08, "t5e_repend");
    rd(IRQ_CLAIM, 32'd3, "t5e_claim2");
    rd(IRQ_CLAIM, 32'd0, "t5e_claim3");
    wr(IRQ_CLAIM, 32'd3);
    settle();
    rd(IRQ_ACTIVE, 32'h0, "t5e_active_done");
    rd(IRQ_PENDING, 32'h0, "t5e_pending_done");

    // Gateway blocking, level mode.
    wr(IRQ_MODE, 32'h0);
    @(negedge clk);
    src[3] = 1'b1;
    settle();
    rd(IRQ_CLAIM, 32'd3, "t5l_claim1");
    wr(IRQ_CLAIM, 32'd3);
    rd(IRQ_PENDING, 32'h0, "t5l_idle_gap");
    rd(IRQ_PENDING, 32'h08, "t5l_repend");
    rd(IRQ_CLAIM, 32'd3, "t5l_claim2");
    @(negedge clk);
    src[3] = 1'b0;
    settle();
    wr(IRQ_CLAIM, 32'd3);
    settle();
    rd(IRQ_PENDING, 32'h0, "t5l_no_repend");
    rd(IRQ_CLAIM, 32'd0, "t5l_claim_none");

    // Corner cases: bogus completes, simultaneous claim/complete, async reset.
    do_reset();
    wr(IRQ_ENABLE, 32'h28);
    wr(IRQ_MODE, 32'h28);
    wr(6'h23, 32'd5);
    wr(6'h25, 32'd2);
    pulse(9'h008);
    settle();
    rd(IRQ_CLAIM, 32'd3, "t6_claim3");
    pulse(9'h008);
    settle();
    wr(IRQ_CLAIM, 32'd7);
    rd(IRQ_ACTIVE, 32'h08, "t6_complete7_ignored");
    wr(IRQ_CLAIM, 32'd0);
    rd(IRQ_ACTIVE, 32'h08, "t6_complete0_ignored");
    rd(IRQ_PENDING, 32'h0, "t6_pending_still0");
    pulse(9'h020);
    settle();
    claim_complete(32'd3, 32'd5, "t6_combo_claim");
    rd(IRQ_ACTIVE, 32'h20, "t6_combo_active");
    rd(IRQ_PENDING, 32'h08, "t6_combo_pending");
    rd(IRQ_CLAIM, 32'd3, "t6_claim_after_combo");
    wr(IRQ_CLAIM, 32'd5);
    pulse(9'h020);
    settle();
    chk_irq_now(1'b1, "t6_irq_before_rst");
    @(negedge clk);
    reg_addr = IRQ_ACTIVE;
    #1;
    expect_val("t6_active_before_rst", 32'h08);
    compare_front(reg_rdata);
    #1;
    rst = 1'b1;
    #1;
    chk_irq_now(1'b0, "t6_irq_async_rst");
    expect_val("t6_active_async_rst", 32'h0);
    compare_front(reg_rdata);
    @(negedge clk);
    rst = 1'b0;
    reg_addr = '0;
    rd(IRQ_ENABLE, 32'h0, "t6_enable_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
